// File: rtl/parking_pkg.sv
// rtl/parking_pkg.sv - shared capture states, digit width and default timing constants
package parking_pkg;

  localparam int DIGIT_W                 = 2;
  localparam int DEFAULT_DEBOUNCE_CYCLES = 16;
  localparam int DEFAULT_TIMEOUT_CYCLES  = 1024;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_D1,
    WAIT_D2,
    HOLD
  } capture_state_t;

endpackage

// File: rtl/sensor_debounce.sv
// rtl/sensor_debounce.sv - two-flop synchronizer plus consecutive-disagreement counter
module sensor_debounce
  import parking_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic i_raw,
  output logic o_level
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       r_sync;
  logic [CNT_W-1:0] r_cnt;
  logic             r_level;

  // The flip happens on the edge that completes the Nth disagreeing sample,
  // so the counter is recycled to zero there instead of ever passing N.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync  <= '0;
      r_cnt   <= '0;
      r_level <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], i_raw};
      if (r_sync[1] == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_cnt   <= '0;
        r_level <= ~r_level;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_level = r_level;

endmodule

// File: rtl/parking_input_frontend.sv
// rtl/parking_input_frontend.sv - sensor debounce and two-digit keypad capture for the gate controller
// Optional entry timeout enabled by PARKING_FRONTEND_TIMEOUT_EN.
module parking_input_frontend
  import parking_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int TIMEOUT_CYCLES  = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               raw_entrance,
  input  logic               raw_exit,
  input  logic               key_valid,
  input  logic [DIGIT_W-1:0] key_digit,
  input  logic               key_clear,
  output logic               sensor_entrance,
  output logic               sensor_exit,
  output logic [DIGIT_W-1:0] password_1,
  output logic [DIGIT_W-1:0] password_2,
  output logic               password_valid,
  output logic               entry_timeout
);

  logic w_ent;
  logic w_ext;
  logic r_ent_prev;
  logic r_ext_prev;
  logic w_ent_rise;
  logic w_ext_rise;

  capture_state_t     r_state;
  capture_state_t     w_next;
  logic [DIGIT_W-1:0] r_pw1;
  logic [DIGIT_W-1:0] r_pw2;
  logic [DIGIT_W-1:0] w_pw1;
  logic [DIGIT_W-1:0] w_pw2;
  logic               w_timeout;
  logic               r_timeout;

  sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_entrance (
    .clk     (clk),
    .reset   (reset),
    .i_raw   (raw_entrance),
    .o_level (w_ent)
  );

  sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_exit (
    .clk     (clk),
    .reset   (reset),
    .i_raw   (raw_exit),
    .o_level (w_ext)
  );

  assign w_ent_rise = w_ent & ~r_ent_prev;
  assign w_ext_rise = w_ext & ~r_ext_prev;

`ifdef PARKING_FRONTEND_TIMEOUT_EN
  localparam int TCNT_W = $clog2(TIMEOUT_CYCLES);

  logic [TCNT_W-1:0] r_tcnt;
  logic              w_waiting;

  assign w_waiting = (r_state == WAIT_D1) || (r_state == WAIT_D2);
  // A digit or clear arriving on the last allowed cycle takes precedence.
  assign w_timeout = w_waiting && !key_clear && !key_valid &&
                     (r_tcnt == TCNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tcnt <= '0;
    end else if (w_waiting && (w_next == r_state)) begin
      r_tcnt <= r_tcnt + TCNT_W'(1);
    end else begin
      r_tcnt <= '0;
    end
  end
`else
  logic w_unused_timeout;

  assign w_unused_timeout = |TIMEOUT_CYCLES;
  assign w_timeout        = 1'b0;
`endif

  always_comb begin
    w_next = r_state;
    w_pw1  = r_pw1;
    w_pw2  = r_pw2;
    if ((r_state != IDLE) && (key_clear || w_timeout)) begin
      w_next = IDLE;
      w_pw1  = '0;
      w_pw2  = '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_ent_rise) w_next = WAIT_D1;
        end
        WAIT_D1: begin
          if (key_valid) begin
            w_pw1  = key_digit;
            w_next = WAIT_D2;
          end
        end
        WAIT_D2: begin
          if (key_valid) begin
            w_pw2  = key_digit;
            w_next = HOLD;
          end
        end
        HOLD: begin
          if (w_ext_rise) begin
            w_next = IDLE;
            w_pw1  = '0;
            w_pw2  = '0;
          end
        end
        default: begin
          w_next = IDLE;
          w_pw1  = '0;
          w_pw2  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_pw1      <= '0;
      r_pw2      <= '0;
      r_timeout  <= 1'b0;
      r_ent_prev <= 1'b0;
      r_ext_prev <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_pw1      <= w_pw1;
      r_pw2      <= w_pw2;
      r_timeout  <= w_timeout;
      r_ent_prev <= w_ent;
      r_ext_prev <= w_ext;
    end
  end

  assign sensor_entrance = w_ent;
  assign sensor_exit     = w_ext;
  assign password_1      = r_pw1;
  assign password_2      = r_pw2;
  assign password_valid  = (r_state == HOLD);
  assign entry_timeout   = r_timeout;

endmodule
